arm_multicycle_ctrl: RTL

//  Multicycle control unit for the ARMv4 subset (ADD/SUB/AND/ORR/CMP/TST, LDR/STR, B).

---
 rtl/arm_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control unit for the ARMv4 subset: a Moore FSM over fetch/decode/execute/memory/writeback,
// with internal flags and condition check. Define ARM_MC_EOR_EN to decode funct[4:1]=0001 as EOR.
module arm_multicycle_ctrl #(
    parameter int MEM_WAIT   = 0,
    parameter int WAIT_CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [2:0]  alu_control,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic        reg_write,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [WAIT_CNT_W-1:0] LP_WAIT_LAST = WAIT_CNT_W'(MEM_WAIT);

    state_t                r_state;
    state_t                w_state_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [3:0]            r_flags;
    logic                  r_cond_ok;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic [3:0] w_cmd;
    logic       w_last_wait;
    logic       w_cond_ok;
    logic       w_unused;

    assign w_cond      = instr[19:16];
    assign w_op        = instr[15:14];
    assign w_funct     = instr[13:8];
    assign w_rd        = instr[3:0];
    assign w_cmd       = w_funct[4:1];
    assign w_last_wait = (r_wait_cnt == LP_WAIT_LAST);
    assign w_unused    = ^instr[7:4];

    // Data-processing decode: ALU op, whether a result is written, whether C/V are meaningful.
    logic [2:0] w_dp_alu;
    logic       w_dp_valid;
    logic       w_dp_nowrite;
    logic       w_dp_arith;
    logic       w_flag_upd;

    always_comb begin
        w_dp_alu     = 3'b000;
        w_dp_valid   = 1'b0;
        w_dp_nowrite = 1'b0;
        w_dp_arith   = 1'b0;
        case (w_cmd)
            4'b0100: begin w_dp_alu = 3'b000; w_dp_valid = 1'b1; w_dp_arith = 1'b1; end
            4'b0010: begin w_dp_alu = 3'b001; w_dp_valid = 1'b1; w_dp_arith = 1'b1; end
            4'b0000: begin w_dp_alu = 3'b010; w_dp_valid = 1'b1; end
            4'b1100: begin w_dp_alu = 3'b011; w_dp_valid = 1'b1; end
            4'b1010: begin w_dp_alu = 3'b001; w_dp_valid = 1'b1; w_dp_nowrite = 1'b1; w_dp_arith = 1'b1; end
            4'b1000: begin w_dp_alu = 3'b010; w_dp_valid = 1'b1; w_dp_nowrite = 1'b1; end
`ifdef ARM_MC_EOR_EN
            4'b0001: begin w_dp_alu = 3'b100; w_dp_valid = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_flag_upd = w_dp_valid & (w_funct[0] | w_dp_nowrite);

    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ok = r_flags[2];
            4'b0001: w_cond_ok = ~r_flags[2];
            4'b0010: w_cond_ok = r_flags[1];
            4'b0011: w_cond_ok = ~r_flags[1];
            4'b0100: w_cond_ok = r_flags[3];
            4'b0101: w_cond_ok = ~r_flags[3];
            4'b0110: w_cond_ok = r_flags[0];
            4'b0111: w_cond_ok = ~r_flags[0];
            4'b1000: w_cond_ok = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ok = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ok = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ok = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ok = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ok = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_flags    <= 4'b0000;
            r_cond_ok  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)
                r_wait_cnt <= '0;
            else if ((r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR) && !w_last_wait)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_state == S_DECODE)
                r_cond_ok <= w_cond_ok;
            // cond_ok was latched in DECODE, so these flag writes cannot affect the current instruction.
            if ((r_state == S_EXECR || r_state == S_EXECI) && r_cond_ok && w_flag_upd) begin
                r_flags[3:2] <= alu_flags[3:2];
                if (w_dp_arith)
                    r_flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    logic w_pc_write;
    logic w_mem_write;
    logic w_ir_write;
    logic w_reg_write;

    always_comb begin
        w_state_next = r_state;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        adr_src      = 1'b0;
        result_src   = 2'b00;
        alu_control  = 3'b000;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        imm_src      = 2'b00;
        case (r_state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (w_last_wait) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (w_op)
                    2'b00:   w_state_next = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_state_next = S_MEMADR;
                    2'b10:   w_state_next = S_BRANCH;
                    default: w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b    = 2'b01;
                imm_src      = 2'b01;
                w_state_next = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (w_last_wait)
                    w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = 2'b01;
                w_reg_write  = r_cond_ok;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                if (w_last_wait) begin
                    w_mem_write  = r_cond_ok;
                    w_state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_control  = w_dp_alu;
                w_state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b    = 2'b01;
                alu_control  = w_dp_alu;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = r_cond_ok & w_dp_valid & ~w_dp_nowrite;
                w_pc_write   = r_cond_ok & w_dp_valid & ~w_dp_nowrite & (w_rd == 4'hF);
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b    = 2'b01;
                imm_src      = 2'b10;
                result_src   = 2'b10;
                w_pc_write   = r_cond_ok;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Register-file read selects follow the instruction so A/B are correct when latched in DECODE.
    assign reg_src[0] = (w_op == 2'b10);
    assign reg_src[1] = (w_op == 2'b01) & ~w_funct[0];

    assign pc_write  = w_pc_write  & ~reset;
    assign mem_write = w_mem_write & ~reset;
    assign ir_write  = w_ir_write  & ~reset;
    assign reg_write = w_reg_write & ~reset;
    assign state_o   = r_state;

endmodule
